// File: rtl/mod_counter_ud_if.sv
// mod_counter_ud_if: control inputs and count/BCD/status outputs
// of one modulo-N up/down counter stage.
interface mod_counter_ud_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  cnt, bcd_tens, bcd_ones, tc, wrap, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output cnt, bcd_tens, bcd_ones, tc, wrap, load_err
    );
endinterface

// File: rtl/mod_counter_ud.sv
// mod_counter_ud: modulo-N up/down counter with cascade tc,
// synchronous clear/load and incrementally kept two-digit BCD.
module mod_counter_ud #(
    parameter int MODULUS = 24,
    parameter int WIDTH   = 6,
    parameter int RST_VAL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_counter_ud_if.slave bus
);
    generate
        if (MODULUS < 2 || MODULUS > 100) begin : g_bad_mod
            $error("mod_counter_ud: MODULUS must be 2..100");
        end
        if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
            $error("mod_counter_ud: WIDTH too small for MODULUS");
        end
        if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_rst
            $error("mod_counter_ud: RST_VAL must be 0..MODULUS-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MOD_C = (WIDTH + 1)'(MODULUS);
    localparam logic [3:0]       MAX_T = 4'((MODULUS - 1) / 10);
    localparam logic [3:0]       MAX_O = 4'((MODULUS - 1) % 10);
    localparam logic [3:0]       RST_T = 4'(RST_VAL / 10);
    localparam logic [3:0]       RST_O = 4'(RST_VAL % 10);

    logic [WIDTH-1:0] cnt_q;
    logic [3:0]       tens_q;
    logic [3:0]       ones_q;
    logic             wrap_q;
    logic             lerr_q;

    logic             over;
    logic [WIDTH-1:0] ld_val;
    logic [6:0]       ld7;
    logic [3:0]       ld_t;
    logic [3:0]       ld_o;
    logic             at_max;
    logic             at_zero;

    // Out-of-range loads saturate to the top count.
    assign over   = {1'b0, bus.load_val} >= MOD_C;
    assign ld_val = over ? MAX_C : bus.load_val;
    assign ld7    = 7'(ld_val);
    assign ld_t   = 4'(ld7 / 7'd10);
    assign ld_o   = 4'(ld7 % 7'd10);

    assign at_max  = (cnt_q == MAX_C);
    assign at_zero = (cnt_q == '0);

    // Ungated by clr/load so a cascade can ripple in one cycle.
    assign bus.tc = bus.en &
                    ((bus.up & at_max) | (~bus.up & at_zero));

    assign bus.cnt      = cnt_q;
    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = lerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_C;
            tens_q <= RST_T;
            ones_q <= RST_O;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
            if (bus.clr) begin
                cnt_q  <= '0;
                tens_q <= '0;
                ones_q <= '0;
            end else if (bus.load) begin
                cnt_q  <= ld_val;
                tens_q <= ld_t;
                ones_q <= ld_o;
                lerr_q <= over;
            end else if (bus.en && bus.up) begin
                if (at_max) begin
                    cnt_q  <= '0;
                    tens_q <= '0;
                    ones_q <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + WIDTH'(1);
                    if (ones_q == 4'd9) begin
                        ones_q <= 4'd0;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        ones_q <= ones_q + 4'd1;
                    end
                end
            end else if (bus.en) begin
                if (at_zero) begin
                    cnt_q  <= MAX_C;
                    tens_q <= MAX_T;
                    ones_q <= MAX_O;
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - WIDTH'(1);
                    if (ones_q == 4'd0) begin
                        ones_q <= 4'd9;
                        tens_q <= tens_q - 4'd1;
                    end else begin
                        ones_q <= ones_q - 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mod_counter_ud.sv
// tb_mod_counter_ud: directed and random stimulus for mod_counter_ud
// against an arithmetic modulo reference model.
module tb_mod_counter_ud;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   m0 = 0;
    int   m7 = 7;

    always #5 clk = ~clk;

    mod_counter_ud_if #(.WIDTH(6)) if0 ();
    mod_counter_ud_if #(.WIDTH(6)) ifs ();
    mod_counter_ud_if #(.WIDTH(6)) ifh ();
    mod_counter_ud_if #(.WIDTH(6)) if7 ();

    mod_counter_ud #(.MODULUS(24), .WIDTH(6), .RST_VAL(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    mod_counter_ud #(.MODULUS(60), .WIDTH(6), .RST_VAL(0)) u_sec (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );
    mod_counter_ud #(.MODULUS(24), .WIDTH(6), .RST_VAL(0)) u_hr (
        .clk(clk), .rst_n(rst_n), .bus(ifh)
    );
    mod_counter_ud #(.MODULUS(24), .WIDTH(6), .RST_VAL(7)) u_r7 (
        .clk(clk), .rst_n(rst_n), .bus(if7)
    );

    assign ifh.en = ifs.tc;

    // Reference: next value by modular arithmetic on plain integers.
    function automatic void model(input int m, input int md,
                                  input bit en, input bit up,
                                  input bit clr, input bit ld,
                                  input int lv, output int nm,
                                  output bit w, output bit le);
        nm = m;
        w  = 1'b0;
        le = 1'b0;
        if (clr) begin
            nm = 0;
        end else if (ld) begin
            le = (lv >= md);
            nm = le ? md - 1 : lv;
        end else if (en) begin
            nm = up ? (m + 1) % md : (m + md - 1) % md;
            w  = up ? (m == md - 1) : (m == 0);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit en, input bit up, input bit clr,
                          input bit ld, input int lv);
        if0.en       = en;
        if0.up       = up;
        if0.clr      = clr;
        if0.load     = ld;
        if0.load_val = 6'(lv);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        drive0(0, 0, 0, 0, 0);
        {if7.en, if7.up, if7.clr, if7.load} = 4'b0;
        if7.load_val = '0;
        {ifs.en, ifs.up, ifs.clr, ifs.load} = 4'b0;
        ifs.load_val = '0;
        {ifh.up, ifh.clr, ifh.load} = 3'b100;
        ifh.load_val = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (if0.cnt !== 6'd0 || if0.bcd_tens !== 4'd0 ||
            if0.bcd_ones !== 4'd0 || if0.wrap !== 1'b0 ||
            if0.load_err !== 1'b0) begin
            failures++;
            $display("FAIL reset0 got cnt=%0d bcd=%0d/%0d w=%b le=%b exp 0 0/0 0 0",
                     if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap, if0.load_err);
        end
        checks++;
        if (if7.cnt !== 6'd7 || if7.bcd_tens !== 4'd0 ||
            if7.bcd_ones !== 4'd7) begin
            failures++;
            $display("FAIL reset7 got cnt=%0d bcd=%0d/%0d exp 7 0/7",
                     if7.cnt, if7.bcd_tens, if7.bcd_ones);
        end
        tick;
        tick;
        rst_n = 1'b1;
        m0 = 0;
        m7 = 7;
    endtask

    task automatic test_count_up;
        int nm;
        bit w, le, etc;
        drive0(1, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            #2;
            etc = (m0 == 23);
            checks++;
            if (if0.tc !== etc) begin
                failures++;
                $display("FAIL up_tc i=%0d got=%b exp=%b", i, if0.tc, etc);
            end
            tick;
            model(m0, 24, 1, 1, 0, 0, 0, nm, w, le);
            m0 = nm;
            checks++;
            if (if0.cnt !== 6'(m0) || if0.bcd_tens !== 4'(m0 / 10) ||
                if0.bcd_ones !== 4'(m0 % 10) || if0.wrap !== w) begin
                failures++;
                $display("FAIL up_step i=%0d got cnt=%0d bcd=%0d/%0d w=%b exp %0d %0d/%0d %b",
                         i, if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap,
                         m0, m0 / 10, m0 % 10, w);
            end
        end
    endtask

    task automatic test_count_down;
        int nm;
        bit w, le, etc;
        drive0(0, 0, 1, 0, 0);
        tick;
        model(m0, 24, 0, 0, 1, 0, 0, nm, w, le);
        m0 = nm;
        drive0(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            etc = (m0 == 0);
            checks++;
            if (if0.tc !== etc) begin
                failures++;
                $display("FAIL dn_tc i=%0d got=%b exp=%b", i, if0.tc, etc);
            end
            tick;
            model(m0, 24, 1, 0, 0, 0, 0, nm, w, le);
            m0 = nm;
            checks++;
            if (if0.cnt !== 6'(m0) || if0.bcd_tens !== 4'(m0 / 10) ||
                if0.bcd_ones !== 4'(m0 % 10) || if0.wrap !== w) begin
                failures++;
                $display("FAIL dn_step i=%0d got cnt=%0d bcd=%0d/%0d w=%b exp %0d %0d/%0d %b",
                         i, if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap,
                         m0, m0 / 10, m0 % 10, w);
            end
        end
    endtask

    task automatic test_load;
        drive0(0, 0, 0, 1, 17);
        tick;
        checks++;
        if (if0.cnt !== 6'd17 || if0.bcd_tens !== 4'd1 ||
            if0.bcd_ones !== 4'd7 || if0.load_err !== 1'b0) begin
            failures++;
            $display("FAIL load17 got cnt=%0d bcd=%0d/%0d le=%b exp 17 1/7 0",
                     if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.load_err);
        end
        drive0(0, 0, 0, 1, 40);
        tick;
        checks++;
        if (if0.cnt !== 6'd23 || if0.bcd_tens !== 4'd2 ||
            if0.bcd_ones !== 4'd3 || if0.load_err !== 1'b1 ||
            if0.wrap !== 1'b0) begin
            failures++;
            $display("FAIL load40 got cnt=%0d bcd=%0d/%0d le=%b w=%b exp 23 2/3 1 0",
                     if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.load_err, if0.wrap);
        end
        drive0(0, 0, 0, 0, 0);
        tick;
        checks++;
        if (if0.cnt !== 6'd23 || if0.load_err !== 1'b0) begin
            failures++;
            $display("FAIL load_hold got cnt=%0d le=%b exp 23 0",
                     if0.cnt, if0.load_err);
        end
        m0 = 23;
    endtask

    task automatic test_priority;
        drive0(0, 0, 0, 1, 12);
        tick;
        drive0(1, 1, 1, 1, 40);
        tick;
        checks++;
        if (if0.cnt !== 6'd0 || if0.bcd_tens !== 4'd0 ||
            if0.bcd_ones !== 4'd0 || if0.wrap !== 1'b0 ||
            if0.load_err !== 1'b0) begin
            failures++;
            $display("FAIL clr_prio got cnt=%0d bcd=%0d/%0d w=%b le=%b exp 0 0/0 0 0",
                     if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap, if0.load_err);
        end
        drive0(1, 1, 0, 1, 5);
        tick;
        checks++;
        if (if0.cnt !== 6'd5 || if0.bcd_ones !== 4'd5 ||
            if0.wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_prio got cnt=%0d ones=%0d w=%b exp 5 5 0",
                     if0.cnt, if0.bcd_ones, if0.wrap);
        end
        drive0(0, 0, 0, 0, 0);
        m0 = 5;
    endtask

    task automatic test_cascade;
        int ms, mh, nm;
        bit ws, wh, le, hen;
        ifs.load = 1'b1;
        ifs.load_val = 6'd59;
        ifh.load = 1'b1;
        ifh.load_val = 6'd23;
        tick;
        ms = 59;
        mh = 23;
        ifs.load = 1'b0;
        ifh.load = 1'b0;
        ifs.en = 1'b1;
        ifs.up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            hen = (ms == 59);
            checks++;
            if (ifs.tc !== hen || ifh.tc !== (hen && mh == 23)) begin
                failures++;
                $display("FAIL casc_tc i=%0d got s=%b h=%b exp s=%b h=%b",
                         i, ifs.tc, ifh.tc, hen, hen && mh == 23);
            end
            tick;
            model(ms, 60, 1, 1, 0, 0, 0, nm, ws, le);
            ms = nm;
            model(mh, 24, hen, 1, 0, 0, 0, nm, wh, le);
            mh = nm;
            checks++;
            if (ifs.cnt !== 6'(ms) || ifh.cnt !== 6'(mh) ||
                ifs.wrap !== ws || ifh.wrap !== wh ||
                ifs.bcd_tens !== 4'(ms / 10) ||
                ifs.bcd_ones !== 4'(ms % 10)) begin
                failures++;
                $display("FAIL casc_step i=%0d got s=%0d h=%0d ws=%b wh=%b exp %0d %0d %b %b",
                         i, ifs.cnt, ifh.cnt, ifs.wrap, ifh.wrap, ms, mh, ws, wh);
            end
        end
        ifs.en = 1'b0;
    endtask

    task automatic test_random;
        int nm, lv;
        bit en, up, clr, ld, w, le, etc;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 7);
            up  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            lv  = int'($urandom_range(0, 63));
            drive0(en, up, clr, ld, lv);
            #2;
            etc = en && ((up && m0 == 23) || (!up && m0 == 0));
            checks++;
            if (if0.tc !== etc) begin
                failures++;
                $display("FAIL rnd_tc i=%0d got=%b exp=%b", i, if0.tc, etc);
            end
            tick;
            model(m0, 24, en, up, clr, ld, lv, nm, w, le);
            m0 = nm;
            checks++;
            if (if0.cnt !== 6'(m0) || if0.bcd_tens !== 4'(m0 / 10) ||
                if0.bcd_ones !== 4'(m0 % 10) || if0.wrap !== w ||
                if0.load_err !== le) begin
                failures++;
                $display("FAIL rnd_step i=%0d got cnt=%0d bcd=%0d/%0d w=%b le=%b exp %0d %0d/%0d %b %b",
                         i, if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap,
                         if0.load_err, m0, m0 / 10, m0 % 10, w, le);
            end
            checks++;
            if (10 * int'(if0.bcd_tens) + int'(if0.bcd_ones) != int'(if0.cnt)) begin
                failures++;
                $display("FAIL bcd_inv i=%0d got bcd=%0d/%0d cnt=%0d",
                         i, if0.bcd_tens, if0.bcd_ones, if0.cnt);
            end
        end
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset;
        drive0(0, 0, 1, 0, 0);
        if7.clr = 1'b1;
        tick;
        drive0(1, 1, 0, 0, 0);
        if7.clr = 1'b0;
        if7.en = 1'b1;
        if7.up = 1'b1;
        repeat (9) tick;
        checks++;
        if (if0.cnt !== 6'd9 || if7.cnt !== 6'd9) begin
            failures++;
            $display("FAIL pre_rst got cnt0=%0d cnt7=%0d exp 9 9",
                     if0.cnt, if7.cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if0.cnt !== 6'd0 || if0.bcd_tens !== 4'd0 ||
            if0.bcd_ones !== 4'd0 || if0.wrap !== 1'b0) begin
            failures++;
            $display("FAIL async_rst0 got cnt=%0d bcd=%0d/%0d w=%b exp 0 0/0 0",
                     if0.cnt, if0.bcd_tens, if0.bcd_ones, if0.wrap);
        end
        checks++;
        if (if7.cnt !== 6'd7 || if7.bcd_tens !== 4'd0 ||
            if7.bcd_ones !== 4'd7) begin
            failures++;
            $display("FAIL async_rst7 got cnt=%0d bcd=%0d/%0d exp 7 0/7",
                     if7.cnt, if7.bcd_tens, if7.bcd_ones);
        end
        tick;
        checks++;
        if (if0.cnt !== 6'd0 || if7.cnt !== 6'd7) begin
            failures++;
            $display("FAIL rst_hold got cnt0=%0d cnt7=%0d exp 0 7",
                     if0.cnt, if7.cnt);
        end
        drive0(0, 0, 0, 0, 0);
        if7.en = 1'b0;
        rst_n = 1'b1;
        m0 = 0;
        m7 = 7;
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_load;
        test_priority;
        test_cascade;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
